// File: rtl/word_serializer_pkg.sv
// serializer_pkg: shared types and defaults for word_serializer and its FIFO.
// Exports state_t, ser_entry_t and the default WIDTH/DEPTH.
package serializer_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;
  typedef enum logic {IDLE, SHIFT} state_t;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic lsb_first;
  } ser_entry_t;
endpackage

// File: rtl/word_serializer_sync_fifo.sv
// sync_fifo: DEPTH-entry synchronous FIFO with a synchronous, active-low reset.
// Ports: clk, rst; push/push_data write; pop/pop_data read the head; full, empty, count.
module sync_fifo
  import serializer_pkg::*;
#(
  parameter type T = ser_entry_t,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign pop_data = mem[rd];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= push_data;
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/word_serializer.sv
// word_serializer: buffers WIDTH-bit words and shifts them out one bit per cycle
// into a downstream serial-in shift register.
// Ports: clk, rst (sync, active-low); in_valid/in_ready/in_data/in_lsb_first upstream;
// ser_d/ser_en/ser_dir to the shift register; word_done on the last bit; busy.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic in_lsb_first,
  output logic ser_d,
  output logic ser_en,
  output logic ser_dir,
  output logic word_done,
  output logic busy
);
  localparam int CNTW = $clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic lsb_first;
  } entry_t;
  entry_t head;
  logic full, empty, pop, last;
  logic [$clog2(DEPTH):0] count;
  state_t state;
  logic [WIDTH-1:0] hold;
  logic [CNTW-1:0] cnt;
  sync_fifo #(.T(entry_t), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid && in_ready),
    .push_data('{data: in_data, lsb_first: in_lsb_first}),
    .pop(pop),
    .pop_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign in_ready = !full && rst;
  assign busy = state == SHIFT || count != '0;
  assign last = state == SHIFT && cnt == CNTW'(WIDTH - 1);
  // Loading on the last bit keeps back-to-back words free of bubbles.
  assign pop = rst && !empty && (state == IDLE || last);
  // hold is pre-shifted so the next bit always sits at hold[1] or hold[WIDTH-2].
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      ser_d <= 1'b0;
      ser_en <= 1'b0;
      ser_dir <= 1'b0;
      word_done <= 1'b0;
    end else if (pop) begin
      state <= SHIFT;
      cnt <= '0;
      hold <= head.data;
      ser_dir <= head.lsb_first;
      ser_en <= 1'b1;
      ser_d <= head.lsb_first ? head.data[0] : head.data[WIDTH-1];
      word_done <= WIDTH == 1;
    end else if (state == SHIFT && !last) begin
      cnt <= cnt + 1'b1;
      hold <= ser_dir ? hold >> 1 : hold << 1;
      ser_d <= ser_dir ? hold[1] : hold[WIDTH-2];
      word_done <= cnt == CNTW'(WIDTH - 2);
    end else begin
      state <= IDLE;
      ser_en <= 1'b0;
      ser_d <= 1'b0;
      word_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench; driver queues expected words, monitor rebuilds them.
module tb_word_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = '0;
  logic in_lsb_first = 1'b0;
  logic ser_d, ser_en, ser_dir, word_done, busy;
  logic [8:0] exp_q[$];
  int acc = 0;
  int started = 0;
  int bitn = 0;
  int npass = 0;
  int ntot = 0;
  word_serializer #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_lsb_first(in_lsb_first),
    .ser_d(ser_d),
    .ser_en(ser_en),
    .ser_dir(ser_dir),
    .word_done(word_done),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Monitor: models the downstream shift register and checks every cycle.
  initial begin
    logic [8:0] cur = '0;
    logic [7:0] recon = '0;
    bit prev_done = 0;
    int prev_occ = 0;
    int occ;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        bitn = 0;
        started = 0;
        recon = '0;
        prev_done = 0;
      end else begin
        if (prev_done && prev_occ > 0) chk("no_bubble", 32'(ser_en), 1);
        if (ser_en) begin
          if (bitn == 0) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(ser_en), 0);
            else cur = exp_q[0];
            started++;
          end
          chk("dir", 32'(ser_dir), 32'(cur[0]));
          recon = cur[0] ? {ser_d, recon[7:1]} : {recon[6:0], ser_d};
          chk("word_done_pos", 32'(word_done), 32'(bitn == 7));
          bitn++;
          if (word_done || bitn == 8) begin
            chk("word", 32'(recon), 32'(cur[8:1]));
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            bitn = 0;
          end
        end else begin
          chk("idle_d", 32'(ser_d), 0);
          chk("idle_done", 32'(word_done), 0);
          if (bitn != 0) begin
            chk("mid_word_gap", 32'(ser_en), 1);
            bitn = 0;
          end
        end
        occ = acc - started;
        chk("in_ready", 32'(in_ready), 32'(occ < 2));
        chk("busy", 32'(busy), 32'(ser_en || occ > 0));
        prev_done = ser_en && word_done;
        prev_occ = occ;
      end
    end
  end
  // Called at a negedge; in_ready depends only on registered state, so it is stable here.
  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_lsb_first = l;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 32'(t), 0);
    else begin
      exp_q.push_back({d, l});
      acc++;
    end
    @(negedge clk);
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(t < 300), 1);
    chk("drained", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_en", 32'(ser_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_done", 32'(word_done), 0);
    chk("rst_d", 32'(ser_d), 0);
    chk("rst_dir", 32'(ser_dir), 0);
    @(negedge clk);
    exp_q.delete();
    acc = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    int t;
    do_reset();
    @(negedge clk);
    send(8'hA5, 1'b0);
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(ser_en), 0);
    @(posedge clk);
    #1;
    chk("lat_first_en", 32'(ser_en), 1);
    chk("lat_first_d", 32'(ser_d), 1);
    wait_idle();
    @(negedge clk);
    send(8'h01, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hFF, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    send(8'h44, 1'b0);
    send(8'h88, 1'b1);
    send(8'h99, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    send(8'h80, 1'b0);
    send(8'h80, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    send(8'hF0, 1'b0);
    send(8'h77, 1'b1);
    send(8'h33, 1'b0);
    in_valid = 1'b0;
    t = 0;
    while (bitn < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mid_word_reached", 32'(bitn), 3);
    do_reset();
    @(negedge clk);
    send(8'h5A, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
